// File: rtl/fifo_bridge_pkg.sv
// Shared constants and the FIFO word layout for the FIFO-to-AXI-Stream read bridge.
package fifo_bridge_pkg;

  // Cycles between fifo_read_en and the word appearing on fifo_data_out.
  localparam int FIFO_RD_LATENCY = 1;
  // Output buffer depth; enough to absorb one read of latency at full rate.
  localparam int BUF_DEPTH = 2;
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Word layout: MSB is the end-of-frame flag, the rest is payload.
  // Modules with a different DATA_WIDTH declare their own copy of this layout.
  typedef struct packed {
    logic                          last;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/fifo_axis_rd_bridge_axis_out_buf.sv
// Two-entry in-order buffer. Slot 0 is always the head; slot 1 holds the
// second-oldest word. The caller guarantees no push when full and no pop when empty.
module axis_out_buf
  import fifo_bridge_pkg::*;
#(
  parameter int W = DEFAULT_DATA_WIDTH + 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic [W-1:0] push_word_i,
  input  logic         pop_i,
  output logic [1:0]   occ_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   occ_q, occ_d;

  // Next-state: shift slot 1 into the head on pop, place a pushed word behind the newest entry.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    occ_d   = occ_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) slot0_d = push_word_i;
        else               slot1_d = push_word_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the pushed word lands directly behind whatever remains.
        if (occ_q == 2'd1) begin
          slot0_d = push_word_i;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_word_i;
        end
      end
      default: ;
    endcase
  end

  // Buffer storage and occupancy register; reset empties it and clears the payload.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      occ_q   <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = slot0_q;

endmodule

// File: rtl/fifo_axis_rd_bridge.sv
// Reads a registered-output FIFO and presents its words as an AXI-Stream master.
// A read is only issued when a buffer slot is guaranteed free by the time the
// word arrives, so the 2-entry buffer can never overflow.
//
// Handshake: a beat transfers on a clock edge where m_axis_tvalid && m_axis_tready.
// tvalid depends only on registered buffer occupancy (never on tready), and once
// tvalid is high, tvalid/tdata/tlast stay constant until that beat transfers.
module fifo_axis_rd_bridge
  import fifo_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH:0]   fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  word_t                head;
  logic [1:0]           occ;
  logic                 inflight_q;
  logic                 pop;
  logic [2:0]           credit;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

  assign m_axis_tvalid = (occ != 2'd0);

  // Credit check: words held plus word in flight, minus the one leaving this cycle, must leave room.
  always_comb begin
    pop          = m_axis_tvalid && m_axis_tready;
    credit       = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_read_en = !reset && !fifo_empty && (credit < 3'(BUF_DEPTH));
    frame_cnt_d  = frame_cnt_q;
    if (pop && head.last) frame_cnt_d = frame_cnt_q + 1'b1;
  end

  // In-flight flag tracks the FIFO read latency; frame counter counts accepted end-of-frame beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      inflight_q  <= fifo_read_en;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  axis_out_buf #(
    .W (DATA_WIDTH + 1)
  ) u_buf (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (inflight_q),
    .push_word_i (fifo_data_out),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_o      (head)
  );

  assign m_axis_tdata = head.data;
  assign m_axis_tlast = head.last;
  assign frame_count  = frame_cnt_q;

endmodule

// File: tb/tb_fifo_axis_rd_bridge.sv
// Bench for fifo_axis_rd_bridge: a behavioural FIFO with 1-cycle read latency feeds
// the bridge; every accepted beat is checked against an in-order expected queue.
module tb_fifo_axis_rd_bridge;

  localparam int DW = 8;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [DW:0]   fifo_data_out;
  logic          fifo_empty;
  logic          fifo_read_en;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [CW-1:0] frame_count;

  fifo_axis_rd_bridge #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_read_en  (fifo_read_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .frame_count   (frame_count)
  );

  // ---------------- models / scoreboard state ----------------
  logic [DW:0]   src_q[$];   // contents of the upstream FIFO
  logic [DW:0]   exp_q[$];   // beats still expected downstream, in order
  logic [CW-1:0] exp_frames;
  int checks = 0;
  int failures = 0;
  int outs, reads_issued, beats, cyc, first_rd, first_vld;
  int vld_run, max_vld_run, pop_run, max_pop_run;
  int tready_mode;           // 0 low, 1 high, 2 toggle, 3 random
  logic hold;                // forces the FIFO to look empty
  logic stall_q;
  logic [DW:0] stall_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic update_empty();
    fifo_empty = hold || (src_q.size() == 0);
  endtask

  task automatic fifo_push(input logic [DW:0] w);
    src_q.push_back(w);
    exp_q.push_back(w);
    update_empty();
  endtask

  task automatic clear_stats();
    reads_issued = 0; beats = 0; first_rd = -1; first_vld = -1;
    vld_run = 0; max_vld_run = 0; pop_run = 0; max_pop_run = 0;
  endtask

  // One clock: sample and score at the falling edge, then advance the FIFO model after the rising edge.
  task automatic tick();
    logic rd, pop;
    logic [DW:0] got;
    @(negedge clk);
    cyc++;
    rd  = fifo_read_en;
    pop = m_axis_tvalid && m_axis_tready;
    got = {m_axis_tlast, m_axis_tdata};
    chk("frame_count", 32'(frame_count), 32'(exp_frames));
    chk("outstanding_le_2", 32'(outs <= 2), 32'd1);
    if (stall_q) begin
      chk("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("hold_word", 32'(got), 32'(stall_word));
    end
    if (rd) begin
      chk("credit_room", 32'((outs - int'(pop)) < 2), 32'd1);
      chk("read_while_empty", 32'(fifo_empty), 32'd0);
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_axis_tvalid && first_vld < 0) first_vld = cyc;
    if (pop) begin
      chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        chk("beat_word", 32'(got), 32'(exp_q[0]));
        if (exp_q[0][DW]) exp_frames = exp_frames + 1'b1;
        void'(exp_q.pop_front());
      end
    end
    stall_q    = m_axis_tvalid && !m_axis_tready;
    stall_word = got;
    vld_run = m_axis_tvalid ? vld_run + 1 : 0;
    if (vld_run > max_vld_run) max_vld_run = vld_run;
    pop_run = pop ? pop_run + 1 : 0;
    if (pop_run > max_pop_run) max_pop_run = pop_run;
    reads_issued += int'(rd);
    beats        += int'(pop);
    @(posedge clk);
    #1;
    outs += int'(rd) - int'(pop);
    if (rd && src_q.size() > 0) fifo_data_out = src_q.pop_front();
    update_empty();
    case (tready_mode)
      0: m_axis_tready = 1'b0;
      1: m_axis_tready = 1'b1;
      2: m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1; hold = 1'b0; m_axis_tready = 1'b0; tready_mode = 0;
    fifo_data_out = '0; fifo_empty = 1'b1;
    outs = 0; cyc = 0; exp_frames = '0; stall_q = 1'b0; stall_word = '0;
    clear_stats();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_read_en", 32'(fifo_read_en), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Full-rate stream, tready held high.
    tready_mode = 1; m_axis_tready = 1'b1; clear_stats();
    for (int i = 0; i < 16; i++) fifo_push({1'(i == 15), 8'(i)});
    drain(100);
    chk("t1_beats", 32'(beats), 32'd16);
    chk("t1_startup", 32'(first_vld - first_rd), 32'd2);
    chk("t1_valid_run", 32'(max_vld_run), 32'd16);
    chk("t1_frames", 32'(frame_count), 32'd1);

    // Same stream with tready toggling every cycle.
    tready_mode = 2; clear_stats();
    for (int i = 0; i < 16; i++) fifo_push({1'(i == 15), 8'(i)});
    drain(200);
    chk("t2_beats", 32'(beats), 32'd16);
    chk("t2_frames", 32'(frame_count), 32'd2);

    // Long backpressure with 8 words waiting.
    tready_mode = 0; m_axis_tready = 1'b0; clear_stats();
    for (int i = 0; i < 8; i++) fifo_push({1'(i == 7), 8'(8'h20 + i)});
    repeat (20) tick();
    chk("t3_reads", 32'(reads_issued), 32'd2);
    chk("t3_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("t3_head", 32'({m_axis_tlast, m_axis_tdata}), 32'h020);
    tready_mode = 1; m_axis_tready = 1'b1; pop_run = 0; max_pop_run = 0;
    drain(50);
    chk("t3_no_gap", 32'(max_pop_run), 32'd8);

    // FIFO runs dry mid-frame, refills later.
    clear_stats();
    for (int i = 0; i < 6; i++) fifo_push({1'b0, 8'(i)});
    drain(50);
    repeat (10) begin
      tick();
      chk("t4_gap_tvalid", 32'(m_axis_tvalid), 32'd0);
    end
    for (int i = 6; i < 16; i++) fifo_push({1'(i == 15), 8'(i)});
    drain(50);
    chk("t4_beats", 32'(beats), 32'd16);

    // Randomized words, tlast, tready and FIFO availability.
    tready_mode = 3; clear_stats();
    for (int i = 0; i < 60; i++) fifo_push({1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255))});
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
        hold = ($urandom_range(0, 3) == 0);
        update_empty();
        tick();
        n++;
      end
      hold = 1'b0; update_empty();
      chk("rand_remaining", 32'(exp_q.size()), 32'd0);
      chk("rand_beats", 32'(beats), 32'd60);
    end

    // Counter wrap: single-beat frames up to 0xFFFE, then two more.
    tready_mode = 1; m_axis_tready = 1'b1;
    begin
      int n = 0;
      while ((exp_frames != 16'hFFFE || exp_q.size() != 0) && n < 70000) begin
        if (src_q.size() < 3 && (int'(exp_frames) + exp_q.size()) < 32'hFFFE)
          fifo_push({1'b1, 8'($urandom_range(0, 255))});
        tick();
        n++;
      end
    end
    tick();
    chk("wrap_fffe", 32'(frame_count), 32'hFFFE);
    fifo_push({1'b1, 8'hA5});
    drain(20); tick();
    chk("wrap_ffff", 32'(frame_count), 32'hFFFF);
    fifo_push({1'b1, 8'h5A});
    drain(20); tick();
    chk("wrap_zero", 32'(frame_count), 32'h0000);

    // Reset with a full buffer under backpressure.
    tready_mode = 0; m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_push({1'(i == 3), 8'(8'h30 + i)});
    repeat (4) tick();
    chk("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    src_q.delete();
    fifo_data_out = '0;
    #1;
    exp_q.delete(); outs = 0; exp_frames = '0; stall_q = 1'b0;
    reset = 1'b0;
    update_empty();
    @(negedge clk);
    chk("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("mid_rst_read_en", 32'(fifo_read_en), 32'd0);
    chk("mid_rst_frames", 32'(frame_count), 32'd0);
    @(posedge clk); #1;
    tready_mode = 1; m_axis_tready = 1'b1; clear_stats();
    for (int i = 0; i < 4; i++) fifo_push({1'(i == 3), 8'(8'h40 + i)});
    drain(30);
    chk("post_rst_beats", 32'(beats), 32'd4);
    chk("post_rst_frames", 32'(frame_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
